// File: rtl/jmb_3x3_window_ctrl_if.sv
// Handshake and window-status bundle between the 3x3 window controller and its neighbours.
// The controller is the slave side; upstream/downstream logic uses the master side.
interface jmb_3x3_window_ctrl_if #(
   parameter int COL_WIDTH = 8,
   parameter int ROW_WIDTH = 8
);
   logic                 start;
   logic                 pix_valid;
   logic                 pix_ready;
   logic                 shift_en;
   logic                 win_valid;
   logic                 win_last;
   logic [COL_WIDTH-1:0] cen_col;
   logic [ROW_WIDTH-1:0] cen_row;
   logic [3:0]           border;
   logic                 busy;
   logic                 frame_done;

   modport master (
      output start, pix_valid,
      input  pix_ready, shift_en, win_valid, win_last, cen_col, cen_row, border, busy, frame_done
   );

   modport slave (
      input  start, pix_valid,
      output pix_ready, shift_en, win_valid, win_last, cen_col, cen_row, border, busy, frame_done
   );
endinterface

// File: rtl/jmb_3x3_window_ctrl.sv
// Fill/run/flush sequencer for the 3x3 window generator with centre coordinates and window strobe.
// Define JMB_WIN_CTRL_BORDER_EN to drive the {top,bottom,left,right} border flags; otherwise border is 0.
module jmb_3x3_window_ctrl #(
   parameter int IMAGE_WIDTH  = 10,
   parameter int IMAGE_HEIGHT = 100,
   parameter int COL_WIDTH    = 8,
   parameter int ROW_WIDTH    = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   jmb_3x3_window_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_pix_ready;
   logic                 r_busy;
   logic                 r_frame_done;
   logic                 r_win_valid;
   logic                 r_win_last;
   logic [COL_WIDTH-1:0] r_in_col;
   logic [ROW_WIDTH-1:0] r_in_row;
   logic [COL_WIDTH-1:0] r_out_col;
   logic [ROW_WIDTH-1:0] r_out_row;
   logic [COL_WIDTH-1:0] r_cen_col;
   logic [ROW_WIDTH-1:0] r_cen_row;

   logic w_accept;
   logic w_shift;
   logic w_produce;
   logic w_in_last_col;
   logic w_in_last_row;
   logic w_out_last_col;
   logic w_out_last_row;
   logic w_fill_done;
   logic w_flush_end;

   // Shift/produce decode and counter terminal-count compares.
   always_comb begin
      w_accept       = bus.pix_valid & r_pix_ready;
      w_shift        = w_accept | (r_state == S_FLUSH);
      w_produce      = w_shift & ((r_state == S_RUN) | (r_state == S_FLUSH));
      w_in_last_col  = (r_in_col == COL_WIDTH'(IMAGE_WIDTH - 1));
      w_in_last_row  = (r_in_row == ROW_WIDTH'(IMAGE_HEIGHT - 1));
      w_out_last_col = (r_out_col == COL_WIDTH'(IMAGE_WIDTH - 1));
      w_out_last_row = (r_out_row == ROW_WIDTH'(IMAGE_HEIGHT - 1));
      // pixel index image_width (row 1, col 0) is the (image_width+1)-th accepted pixel
      w_fill_done    = w_accept & (r_in_row == ROW_WIDTH'(1)) & (r_in_col == {COL_WIDTH{1'b0}});
      w_flush_end    = (r_in_col == COL_WIDTH'(IMAGE_WIDTH));
   end

   // Frame sequencer; the input column counter doubles as the flush shift counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_pix_ready  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_in_col     <= {COL_WIDTH{1'b0}};
         r_in_row     <= {ROW_WIDTH{1'b0}};
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // a start coinciding with frame_done belongs to the frame just finished
               if (bus.start && !r_frame_done) begin
                  r_state     <= S_FILL;
                  r_pix_ready <= 1'b1;
                  r_busy      <= 1'b1;
                  r_in_col    <= {COL_WIDTH{1'b0}};
                  r_in_row    <= {ROW_WIDTH{1'b0}};
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_FILL, S_RUN: begin
               if (w_accept) begin
                  if (w_fill_done) begin
                     r_state <= S_RUN;
                  end else begin
                     r_state <= r_state;
                  end
                  if (w_in_last_col && w_in_last_row) begin
                     r_state     <= S_FLUSH;
                     r_pix_ready <= 1'b0;
                     r_in_col    <= {COL_WIDTH{1'b0}};
                     r_in_row    <= {ROW_WIDTH{1'b0}};
                  end else if (w_in_last_col) begin
                     r_in_col <= {COL_WIDTH{1'b0}};
                     r_in_row <= r_in_row + ROW_WIDTH'(1);
                  end else begin
                     r_in_col <= r_in_col + COL_WIDTH'(1);
                  end
               end else begin
                  r_state <= r_state;
               end
            end
            S_FLUSH: begin
               if (w_flush_end) begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_in_col     <= {COL_WIDTH{1'b0}};
               end else begin
                  r_in_col <= r_in_col + COL_WIDTH'(1);
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_pix_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_in_col    <= {COL_WIDTH{1'b0}};
               r_in_row    <= {ROW_WIDTH{1'b0}};
            end
         endcase
      end
   end

   // Window strobe and centre coordinates, updated on the producing shift edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_win_valid <= 1'b0;
         r_win_last  <= 1'b0;
         r_out_col   <= {COL_WIDTH{1'b0}};
         r_out_row   <= {ROW_WIDTH{1'b0}};
         r_cen_col   <= {COL_WIDTH{1'b0}};
         r_cen_row   <= {ROW_WIDTH{1'b0}};
      end else begin
         r_win_valid <= w_produce;
         if (w_produce) begin
            r_win_last <= w_out_last_col & w_out_last_row;
            r_cen_col  <= r_out_col;
            r_cen_row  <= r_out_row;
            if (w_out_last_col) begin
               r_out_col <= {COL_WIDTH{1'b0}};
               r_out_row <= w_out_last_row ? {ROW_WIDTH{1'b0}} : r_out_row + ROW_WIDTH'(1);
            end else begin
               r_out_col <= r_out_col + COL_WIDTH'(1);
            end
         end else if ((r_state == S_IDLE) && bus.start) begin
            r_win_last <= 1'b0;
            r_out_col  <= {COL_WIDTH{1'b0}};
            r_out_row  <= {ROW_WIDTH{1'b0}};
         end else begin
            r_win_last <= 1'b0;
         end
      end
   end

`ifdef JMB_WIN_CTRL_BORDER_EN
   logic [3:0] r_border;

   function automatic logic [3:0] calc_border(input logic [COL_WIDTH-1:0] col,
                                              input logic [ROW_WIDTH-1:0] row);
      calc_border = {(row == {ROW_WIDTH{1'b0}}),
                     (row == ROW_WIDTH'(IMAGE_HEIGHT - 1)),
                     (col == {COL_WIDTH{1'b0}}),
                     (col == COL_WIDTH'(IMAGE_WIDTH - 1))};
   endfunction

   // Border flags registered alongside the centre they describe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_border <= 4'b0000;
      end else if (w_produce) begin
         r_border <= calc_border(r_out_col, r_out_row);
      end else begin
         r_border <= r_border;
      end
   end

   assign bus.border = r_border;
`else
   assign bus.border = 4'b0000;
`endif

   assign bus.pix_ready  = r_pix_ready;
   assign bus.shift_en   = w_shift;
   assign bus.win_valid  = r_win_valid;
   assign bus.win_last   = r_win_last;
   assign bus.cen_col    = r_cen_col;
   assign bus.cen_row    = r_cen_row;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_jmb_3x3_window_ctrl.sv
// Self-checking bench for jmb_3x3_window_ctrl: a 10x4 instance and a 3x2 instance against a
// count-based frame model, plus constant vector tables for reset/idle and border corners.
module tb_jmb_3x3_window_ctrl;

   logic clk;
   logic rst_a;
   logic rst_b;
   logic start_s;
   logic pv_s;

   jmb_3x3_window_ctrl_if #(.COL_WIDTH(8), .ROW_WIDTH(8)) ifa ();
   jmb_3x3_window_ctrl_if #(.COL_WIDTH(8), .ROW_WIDTH(8)) ifb ();

   assign ifa.start     = start_s;
   assign ifa.pix_valid = pv_s;
   assign ifb.start     = start_s;
   assign ifb.pix_valid = pv_s;

   jmb_3x3_window_ctrl #(.IMAGE_WIDTH(10), .IMAGE_HEIGHT(4), .COL_WIDTH(8), .ROW_WIDTH(8)) dut_a (
      .clock   (clk),
      .reset_n (rst_a),
      .bus     (ifa.slave)
   );

   jmb_3x3_window_ctrl #(.IMAGE_WIDTH(3), .IMAGE_HEIGHT(2), .COL_WIDTH(8), .ROW_WIDTH(8)) dut_b (
      .clock   (clk),
      .reset_n (rst_b),
      .bus     (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 0;
   int mw       = 10;
   int mh       = 4;

   // frame model: phase 0 idle, 1 accepting pixels, 2 flushing
   int         m_phase;
   int         m_acc;
   int         m_flush;
   bit         m_done;
   bit         m_wv;
   bit         m_wl;
   int         m_col;
   int         m_row;
   logic [3:0] m_bd;

   int          win_cnt;
   int          shift_cnt;
   int          tb_zero;
   logic [25:0] last_act;
   logic [3:0]  seen_bd [0:63];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] border_of(input int c, input int r);
`ifdef JMB_WIN_CTRL_BORDER_EN
      return {(r == 0), (r == mh - 1), (c == 0), (c == mw - 1)};
`else
      return 4'b0000;
`endif
   endfunction

   task automatic model_reset();
      m_phase = 0; m_acc = 0; m_flush = 0; m_done = 1'b0;
      m_wv = 1'b0; m_wl = 1'b0; m_col = 0; m_row = 0; m_bd = 4'b0000;
   endtask

   task automatic model_advance(input bit st, input bit pv);
      int idx;
      bit prod;
      int nphase;
      bit ndone;
      prod = 1'b0; idx = 0; ndone = 1'b0; nphase = m_phase;
      if (m_phase == 1) begin
         if (pv) begin
            if (m_acc >= mw + 1) begin
               prod = 1'b1;
               idx  = m_acc - (mw + 1);
            end
            m_acc++;
            if (m_acc == mw * mh) begin
               nphase  = 2;
               m_flush = 0;
            end
         end
      end else if (m_phase == 2) begin
         prod = 1'b1;
         idx  = mw * mh - (mw + 1) + m_flush;
         m_flush++;
         if (m_flush == mw + 1) begin
            nphase = 0;
            ndone  = 1'b1;
         end
      end else if (st && !m_done) begin
         nphase = 1;
         m_acc  = 0;
      end
      m_phase = nphase;
      m_done  = ndone;
      m_wv    = prod;
      m_wl    = prod && (idx == mw * mh - 1);
      if (prod) begin
         m_col = idx % mw;
         m_row = idx / mw;
         m_bd  = border_of(m_col, m_row);
      end
   endtask

   function automatic logic [25:0] sample();
      if (sel == 0)
         return {ifa.pix_ready, ifa.shift_en, ifa.win_valid, ifa.win_last, ifa.busy,
                 ifa.frame_done, ifa.border, ifa.cen_col, ifa.cen_row};
      else
         return {ifb.pix_ready, ifb.shift_en, ifb.win_valid, ifb.win_last, ifb.busy,
                 ifb.frame_done, ifb.border, ifb.cen_col, ifb.cen_row};
   endfunction

   // One clock cycle: drive at the falling edge, compare against the model, then advance it.
   task automatic step(input bit st, input bit pv, input bit rst);
      logic [25:0] act;
      logic [25:0] exp;
      int          bi;
      @(negedge clk);
      start_s = st;
      pv_s    = pv;
      if (sel == 0) begin rst_a = rst; rst_b = 1'b0; end
      else          begin rst_b = rst; rst_a = 1'b0; end
      #1;
      if (!rst) model_reset();
      exp = {(m_phase == 1), ((m_phase == 1) && pv) || (m_phase == 2), m_wv, m_wl,
             (m_phase != 0), m_done, m_bd, 8'(m_col), 8'(m_row)};
      act = sample();
      chk("cycle", 32'(act), 32'(exp));
      if (act[23]) begin
         win_cnt++;
         bi = int'(act[7:0]) * mw + int'(act[15:8]);
         if (sel == 0 && bi < 64) seen_bd[bi] = act[19:16];
         if (sel == 1 && act[19:18] == 2'b00) tb_zero++;
      end
      if (act[24]) shift_cnt++;
      last_act = act;
      if (rst) model_advance(st, pv);
   endtask

   // mode 0 continuous, 1 alternate-cycle pix_valid, 2 random pix_valid with random start pulses.
   task automatic run_frame(input int mode, input bit probe_done);
      int cyc;
      bit pv;
      bit st;
      win_cnt = 0; shift_cnt = 0;
      step(1'b1, 1'b0, 1'b1);
      cyc = 0;
      while ((m_phase != 0 || m_done) && cyc < 4000) begin
         case (mode)
            0:       pv = 1'b1;
            1:       pv = (cyc % 2 == 1);
            2:       pv = ($urandom_range(0, 3) != 0);
            default: pv = 1'b1;
         endcase
         st = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
         if (probe_done && m_done) st = 1'b1;
         step(st, pv, 1'b1);
         cyc++;
      end
      n_checks++;
      if (cyc >= 4000) begin
         n_fail++;
         $display("FAIL frame_bound actual=%0d cycles required=<4000", cyc);
      end
      chk("win_count", 32'(win_cnt), 32'(mw * mh));
      chk("shift_count", 32'(shift_cnt), 32'(mw * mh + mw + 1));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
      chk("idle_after_frame", 32'(last_act[21]), 32'd0);
   endtask

   typedef struct {
      bit         rst;
      bit         st;
      bit         pv;
      logic [3:0] exp;   // {pix_ready, shift_en, busy, win_valid}
   } vec_t;

   typedef struct {
      int         col;
      int         row;
      logic [3:0] exp;
   } bvec_t;

   initial begin
      vec_t  tv [10];
      bvec_t bt [3];

      tv[0] = '{1'b0, 1'b0, 1'b1, 4'b0000};
      tv[1] = '{1'b0, 1'b1, 1'b1, 4'b0000};
      tv[2] = '{1'b1, 1'b0, 1'b1, 4'b0000};
      tv[3] = '{1'b1, 1'b0, 1'b1, 4'b0000};
      tv[4] = '{1'b1, 1'b1, 1'b0, 4'b0000};
      tv[5] = '{1'b1, 1'b0, 1'b0, 4'b1010};
      tv[6] = '{1'b1, 1'b0, 1'b1, 4'b1110};
      tv[7] = '{1'b1, 1'b0, 1'b1, 4'b1110};
      tv[8] = '{1'b0, 1'b0, 1'b1, 4'b0000};
      tv[9] = '{1'b1, 1'b0, 1'b1, 4'b0000};
`ifdef JMB_WIN_CTRL_BORDER_EN
      bt[0] = '{0, 0, 4'b1010};
      bt[1] = '{9, 3, 4'b0101};
      bt[2] = '{5, 1, 4'b0000};
`else
      bt[0] = '{0, 0, 4'b0000};
      bt[1] = '{9, 3, 4'b0000};
      bt[2] = '{5, 1, 4'b0000};
`endif
      for (int i = 0; i < 64; i++) seen_bd[i] = 4'bxxxx;

      rst_a = 1'b0; rst_b = 1'b0; start_s = 1'b0; pv_s = 1'b1;
      win_cnt = 0; shift_cnt = 0; tb_zero = 0;
      sel = 0; mw = 10; mh = 4;
      model_reset();

      // reset, idle, start latency and a second reset
      for (int i = 0; i < 10; i++) begin
         step(tv[i].st, tv[i].pv, tv[i].rst);
         chk("reset_idle_vec", 32'({last_act[25], last_act[24], last_act[21], last_act[23]}),
             32'(tv[i].exp));
         if (!tv[i].rst) chk("reset_values", 32'(last_act), 32'd0);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
      chk("idle_busy", 32'(last_act[21]), 32'd0);
      chk("idle_no_shift", 32'(last_act[24]), 32'd0);

      // continuous frame, start pulsed in the frame_done cycle
      run_frame(0, 1'b1);
      for (int i = 0; i < 3; i++)
         chk("border_corner", 32'(seen_bd[bt[i].row * 10 + bt[i].col]), 32'(bt[i].exp));

      // alternate-cycle stalls, then random stalls
      run_frame(1, 1'b0);
      run_frame(2, 1'b0);
      run_frame(2, 1'b1);

      // start during RUN is ignored; reset at pixel 20 returns to IDLE at once
      step(1'b1, 1'b0, 1'b1);
      while (m_acc < 15 && m_phase == 1) step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      while (m_acc < 20 && m_phase == 1) step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      chk("midframe_reset", 32'(last_act), 32'd0);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("post_reset_idle", 32'(last_act[21]), 32'd0);
      run_frame(0, 1'b0);

      // minimum geometry on the 3x2 instance
      sel = 1; mw = 3; mh = 2;
      model_reset();
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      tb_zero = 0;
      run_frame(0, 1'b0);
      run_frame(2, 1'b0);
`ifdef JMB_WIN_CTRL_BORDER_EN
      chk("min_top_bottom_clear", 32'(tb_zero), 32'd0);
`else
      chk("min_border_off_windows", 32'(tb_zero), 32'd12);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
